// File: rtl/csr_file_pkg.sv
// Shared CSR definitions: addresses, field positions, request payload and RMW helper.
package csr_file_pkg;

  localparam int unsigned CSR_ADDR_W = 12;

  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MIE      = 12'h304;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MTVEC    = 12'h305;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MCAUSE   = 12'h342;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MTVAL    = 12'h343;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MIP      = 12'h344;
  localparam logic [CSR_ADDR_W-1:0] CSR_ADDR_MHARTID  = 12'hF14;

  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MSTATUS_MPP_LSB  = 11;
  localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;

  localparam int unsigned MIP_MSIP = 3;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  localparam int unsigned IRQ_CODE_W   = 5;
  localparam logic [IRQ_CODE_W-1:0] IRQ_CODE_MSI = 5'd3;
  localparam logic [IRQ_CODE_W-1:0] IRQ_CODE_MTI = 5'd7;
  localparam logic [IRQ_CODE_W-1:0] IRQ_CODE_MEI = 5'd11;

  typedef enum logic [1:0] {
    MTVEC_MODE_DIRECT   = 2'd0,
    MTVEC_MODE_VECTORED = 2'd1
  } mtvec_mode_t;

  typedef enum logic [1:0] {
    CSR_MODE_NONE = 2'd0,
    CSR_MODE_RW   = 2'd1,
    CSR_MODE_RS   = 2'd2,
    CSR_MODE_RC   = 2'd3
  } csr_mode_t;

  typedef struct packed {
    logic                  valid;
    logic                  use_imm;
    csr_mode_t             csr_mode;
    logic [CSR_ADDR_W-1:0] csr_target;
  } csr_req_t;

  // Read-modify-write result for one CSR instruction.
  function automatic logic [31:0] csr_apply(input csr_mode_t mode,
                                            input logic [31:0] old_val,
                                            input logic [31:0] op);
    logic [31:0] res;
    case (mode)
      CSR_MODE_RW: res = op;
      CSR_MODE_RS: res = old_val | op;
      CSR_MODE_RC: res = old_val & ~op;
      default:     res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_irq_sync.sv
// Multi-flop synchronizer bringing one asynchronous interrupt level into clk.
module csr_irq_sync
  import csr_file_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq_async,
  output logic irq_sync
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; the oldest sample is the synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], irq_async};
    end
  end

  assign irq_sync = sync_q[STAGES-1];

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR read-modify-write, trap entry, mret and interrupt detect.
module csr_file
  import csr_file_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HART_ID     = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  csr_req_t        csr_req,
  input  logic            csr_commit,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      zimm,
  output logic [XLEN-1:0] csr_rdata,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_o,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic            irq_take,
  output logic [XLEN-1:0] irq_cause
);

  logic            mstatus_mie_q;
  logic            mstatus_mpie_q;
  logic            mie_msie_q;
  logic            mie_mtie_q;
  logic            mie_meie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  logic            irq_sw_s;
  logic            irq_timer_s;
  logic            irq_ext_s;

  logic [XLEN-1:0] mstatus_v;
  logic [XLEN-1:0] mie_v;
  logic [XLEN-1:0] mip_v;
  logic [XLEN-1:0] rdata_raw;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;
  logic [XLEN-1:0] irq_pend;
  logic            csr_we;
  logic            op_is_set_clr;

  csr_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_sw (
    .clk(clk), .rst_n(rst_n), .irq_async(irq_sw), .irq_sync(irq_sw_s)
  );
  csr_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_timer (
    .clk(clk), .rst_n(rst_n), .irq_async(irq_timer), .irq_sync(irq_timer_s)
  );
  csr_irq_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk(clk), .rst_n(rst_n), .irq_async(irq_ext), .irq_sync(irq_ext_s)
  );

  // Architectural views of the sparse registers.
  always_comb begin
    mstatus_v = '0;
    mstatus_v[MSTATUS_MPP_LSB +: 2] = MSTATUS_MPP_M;
    mstatus_v[MSTATUS_MIE_BIT]      = mstatus_mie_q;
    mstatus_v[MSTATUS_MPIE_BIT]     = mstatus_mpie_q;
    mie_v           = '0;
    mie_v[MIP_MSIP] = mie_msie_q;
    mie_v[MIP_MTIP] = mie_mtie_q;
    mie_v[MIP_MEIP] = mie_meie_q;
    mip_v           = '0;
    mip_v[MIP_MSIP] = irq_sw_s;
    mip_v[MIP_MTIP] = irq_timer_s;
    mip_v[MIP_MEIP] = irq_ext_s;
  end

  // Read mux over the addressed CSR; unknown addresses read zero.
  always_comb begin
    rdata_raw = '0;
    case (csr_req.csr_target)
      CSR_ADDR_MSTATUS:  rdata_raw = mstatus_v;
      CSR_ADDR_MIE:      rdata_raw = mie_v;
      CSR_ADDR_MTVEC:    rdata_raw = mtvec_q;
      CSR_ADDR_MSCRATCH: rdata_raw = mscratch_q;
      CSR_ADDR_MEPC:     rdata_raw = mepc_q;
      CSR_ADDR_MCAUSE:   rdata_raw = mcause_q;
      CSR_ADDR_MTVAL:    rdata_raw = mtval_q;
      CSR_ADDR_MIP:      rdata_raw = mip_v;
      CSR_ADDR_MHARTID:  rdata_raw = XLEN'(HART_ID);
      default:           rdata_raw = '0;
    endcase
  end

  assign csr_rdata = csr_req.valid ? rdata_raw : '0;

  // Operand select and write qualification; traps and mret squash the CSR write.
  always_comb begin
    operand       = csr_req.use_imm ? XLEN'(zimm) : rs1_data;
    new_val       = csr_apply(csr_req.csr_mode, rdata_raw, operand);
    op_is_set_clr = (csr_req.csr_mode == CSR_MODE_RS) || (csr_req.csr_mode == CSR_MODE_RC);
    csr_we        = csr_req.valid && csr_commit && (csr_req.csr_mode != CSR_MODE_NONE) &&
                    !(op_is_set_clr && (operand == '0)) && !trap_valid && !mret;
  end

  // mstatus interrupt-enable stack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
    end else if (trap_valid) begin
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (mret) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (csr_we && (csr_req.csr_target == CSR_ADDR_MSTATUS)) begin
      mstatus_mie_q  <= new_val[MSTATUS_MIE_BIT];
      mstatus_mpie_q <= new_val[MSTATUS_MPIE_BIT];
    end
  end

  // Trap state: mepc, mcause, mtval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q   <= '0;
      mcause_q <= '0;
      mtval_q  <= '0;
    end else if (trap_valid) begin
      mepc_q   <= trap_pc & ~XLEN'(3);
      mcause_q <= trap_cause;
      mtval_q  <= trap_tval;
    end else if (csr_we) begin
      if (csr_req.csr_target == CSR_ADDR_MEPC)   mepc_q   <= new_val & ~XLEN'(3);
      if (csr_req.csr_target == CSR_ADDR_MCAUSE) mcause_q <= new_val;
      if (csr_req.csr_target == CSR_ADDR_MTVAL)  mtval_q  <= new_val;
    end
  end

  // Plain software-written registers: mie, mtvec, mscratch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_msie_q <= 1'b0;
      mie_mtie_q <= 1'b0;
      mie_meie_q <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else if (csr_we) begin
      if (csr_req.csr_target == CSR_ADDR_MIE) begin
        mie_msie_q <= new_val[MIP_MSIP];
        mie_mtie_q <= new_val[MIP_MTIP];
        mie_meie_q <= new_val[MIP_MEIP];
      end
      if (csr_req.csr_target == CSR_ADDR_MTVEC) begin
        mtvec_q <= {new_val[XLEN-1:2], 1'b0,
                    new_val[1:0] == 2'(MTVEC_MODE_VECTORED)};
      end
      if (csr_req.csr_target == CSR_ADDR_MSCRATCH) mscratch_q <= new_val;
    end
  end

  // Handler address; vectored mode offsets interrupts by 4*code.
  always_comb begin
    trap_vector = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[0] && trap_cause[XLEN-1]) begin
      trap_vector = {mtvec_q[XLEN-1:2], 2'b00} + XLEN'({trap_cause[4:0], 2'b00});
    end
  end

  // Pending-and-enabled interrupt selection, external first.
  always_comb begin
    irq_pend  = mie_v & mip_v;
    irq_take  = mstatus_mie_q && (irq_pend != '0);
    irq_cause = '0;
    if (irq_take) begin
      irq_cause[XLEN-1] = 1'b1;
      if (irq_pend[MIP_MEIP])      irq_cause[IRQ_CODE_W-1:0] = IRQ_CODE_MEI;
      else if (irq_pend[MIP_MSIP]) irq_cause[IRQ_CODE_W-1:0] = IRQ_CODE_MSI;
      else                         irq_cause[IRQ_CODE_W-1:0] = IRQ_CODE_MTI;
    end
  end

  assign mepc_o = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file with a CSR-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_csr_file;
  import csr_file_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HART = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  csr_req_t    csr_req;
  logic        csr_commit;
  logic [31:0] rs1_data;
  logic [4:0]  zimm;
  logic [31:0] csr_rdata;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret;
  logic [31:0] trap_vector;
  logic [31:0] mepc_o;
  logic        irq_sw;
  logic        irq_timer;
  logic        irq_ext;
  logic        irq_take;
  logic [31:0] irq_cause;

  int vectors = 0;
  int miscompares = 0;

  csr_file #(.XLEN(32), .HART_ID(HART), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .csr_req(csr_req), .csr_commit(csr_commit),
    .rs1_data(rs1_data), .zimm(zimm), .csr_rdata(csr_rdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret(mret), .trap_vector(trap_vector), .mepc_o(mepc_o),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .irq_take(irq_take), .irq_cause(irq_cause)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (architectural CSR values) ----------------
  bit [31:0] m_mstatus = 32'h1800;
  bit [31:0] m_mie = 0, m_mtvec = 0, m_mscratch = 0, m_mepc = 0, m_mcause = 0, m_mtval = 0;
  bit [2:0]  pin_hist[$];  // {ext,timer,sw} seen at each clock edge since reset

  function automatic bit [31:0] m_mip();
    bit [2:0] s;
    if (pin_hist.size() < SYNC) return 32'h0;
    s = pin_hist[pin_hist.size() - SYNC];
    return (s[2] ? 32'h800 : 32'h0) | (s[1] ? 32'h80 : 32'h0) | (s[0] ? 32'h8 : 32'h0);
  endfunction

  function automatic bit [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
      12'hF14: return 32'(HART);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [31:0] m_vector(input logic [31:0] cause);
    bit [31:0] base = m_mtvec & 32'hFFFF_FFFC;
    if (m_mtvec[1:0] == 2'd1 && cause[31]) return base + 4 * 32'(cause[4:0]);
    return base;
  endfunction

  function automatic bit [31:0] m_take();
    return (m_mstatus[3] && ((m_mie & m_mip()) != 0)) ? 32'd1 : 32'd0;
  endfunction

  function automatic bit [31:0] m_cause();
    bit [31:0] p = m_mie & m_mip();
    if (m_take() == 0) return 32'h0;
    if (p[11]) return 32'h8000_000B;
    if (p[3])  return 32'h8000_0003;
    return 32'h8000_0007;
  endfunction

  task automatic m_csr_write();
    bit [31:0] op, nv;
    op = csr_req.use_imm ? 32'(zimm) : rs1_data;
    case (csr_req.csr_mode)
      CSR_MODE_RW: nv = op;
      CSR_MODE_RS: begin if (op == 0) return; nv = m_read(csr_req.csr_target) | op; end
      CSR_MODE_RC: begin if (op == 0) return; nv = m_read(csr_req.csr_target) & ~op; end
      default: return;
    endcase
    case (csr_req.csr_target)
      12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
      12'h304: m_mie      = nv & 32'h888;
      12'h305: m_mtvec    = (nv & 32'hFFFF_FFFC) | ((nv[1:0] == 2'd1) ? 32'd1 : 32'd0);
      12'h340: m_mscratch = nv;
      12'h341: m_mepc     = nv & 32'hFFFF_FFFC;
      12'h342: m_mcause   = nv;
      12'h343: m_mtval    = nv;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0;
      pin_hist.delete();
    end else begin
      if (trap_valid) begin
        m_mepc    = trap_pc & 32'hFFFF_FFFC;
        m_mcause  = trap_cause;
        m_mtval   = trap_tval;
        m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (mret) begin
        m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end else if (csr_req.valid && csr_commit) begin
        m_csr_write();
      end
      pin_hist.push_back({irq_ext, irq_timer, irq_sw});
      if (pin_hist.size() > 8) void'(pin_hist.pop_front());
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_rdata", csr_rdata, csr_req.valid ? m_read(csr_req.csr_target) : 32'h0);
    check("cyc_vector", trap_vector, m_vector(trap_cause));
    check("cyc_mepc", mepc_o, m_mepc);
    check("cyc_take", {31'b0, irq_take}, m_take());
    check("cyc_cause", irq_cause, m_cause());
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input logic v, input logic imm, input csr_mode_t mode,
                         input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] zi, input logic commit);
    csr_req.valid      = v;
    csr_req.use_imm    = imm;
    csr_req.csr_mode   = mode;
    csr_req.csr_target = addr;
    rs1_data           = rs1;
    zimm               = zi;
    csr_commit         = commit;
  endtask

  task automatic rd(input logic [11:0] addr);
    set_req(1'b1, 1'b1, CSR_MODE_RS, addr, 32'h0, 5'd0, 1'b0);
    #1;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, CSR_MODE_NONE, 12'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] rd_addr [9];
  logic [31:0] rd_exp  [9];
  int n;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_addr = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hF14};
    rd_exp  = '{32'h1800, 0, 0, 0, 0, 0, 0, 0, 32'd5};
    idle();
    trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret = 0;
    irq_sw = 0; irq_timer = 0; irq_ext = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // reset values of all nine CSRs
    for (int i = 0; i < 9; i++) begin
      rd(rd_addr[i]);
      check($sformatf("reset_read_%03h", rd_addr[i]), csr_rdata, rd_exp[i]);
    end
    idle(); #1;
    check("rdata_invalid", csr_rdata, 32'h0);
    check("reset_take", {31'b0, irq_take}, 32'h0);
    check("reset_vector", trap_vector, 32'h0);

    // mscratch RW, then RS with zero immediate leaves it alone, then RC
    set_req(1, 0, CSR_MODE_RW, 12'h340, 32'hDEADBEEF, 0, 1); #1;
    check("rw_old", csr_rdata, 32'h0);
    step();
    set_req(1, 1, CSR_MODE_RS, 12'h340, 32'h0, 0, 1); #1;
    check("rsi0_old", csr_rdata, 32'hDEADBEEF);
    step(); #1;
    check("rsi0_keep", csr_rdata, 32'hDEADBEEF);
    set_req(1, 0, CSR_MODE_RC, 12'h340, 32'h0000FFFF, 0, 1);
    step(); rd(12'h340);
    check("rc_result", csr_rdata, 32'hDEAD0000);
    set_req(1, 0, CSR_MODE_RW, 12'h340, 32'h1, 0, 0);
    step(); rd(12'h340);
    check("uncommitted", csr_rdata, 32'hDEAD0000);

    // mtvec WARL mode and vectored trap address
    set_req(1, 0, CSR_MODE_RW, 12'h305, 32'hFFFFFFFF, 0, 1);
    step(); rd(12'h305);
    check("mtvec_warl", csr_rdata, 32'hFFFFFFFC);
    set_req(1, 0, CSR_MODE_RW, 12'h305, 32'h1001, 0, 1);
    step(); idle();
    trap_valid = 1; trap_cause = 32'h80000007; trap_pc = 32'h503; trap_tval = 32'h77; #1;
    check("vec_irq7", trap_vector, 32'h101C);
    trap_cause = 32'h2; #1;
    check("vec_exc", trap_vector, 32'h1000);
    trap_cause = 32'h80000007;
    step(); trap_valid = 0;
    check("trap_mepc", mepc_o, 32'h500);
    rd(12'h342); check("trap_mcause", csr_rdata, 32'h80000007);
    rd(12'h343); check("trap_mtval", csr_rdata, 32'h77);

    // timer interrupt latency and trap acceptance
    set_req(1, 1, CSR_MODE_RS, 12'h300, 32'h0, 5'd8, 1);
    step();
    set_req(1, 0, CSR_MODE_RW, 12'h304, 32'h80, 0, 1);
    step(); rd(12'h300);
    check("mstatus_mie", csr_rdata, 32'h1808);
    idle();
    irq_timer = 1;
    n = 0;
    while (!irq_take && n < 10) begin step(); n++; end
    check("irq_latency", 32'(n), 32'(SYNC));
    check("irq_cause_t", irq_cause, 32'h80000007);
    trap_valid = 1; trap_pc = 32'h1234; trap_cause = 32'h80000007;
    step(); trap_valid = 0; #1;
    check("irq_trap_mepc", mepc_o, 32'h1234);
    check("irq_trap_take", {31'b0, irq_take}, 32'h0);
    rd(12'h300); check("irq_trap_mstatus", csr_rdata, 32'h1880);
    irq_timer = 0;

    // software+external pending, mret re-enables
    irq_sw = 1; irq_ext = 1;
    set_req(1, 0, CSR_MODE_RW, 12'h304, 32'hFFFFFFFF, 0, 1);
    step(); rd(12'h304);
    check("mie_warl", csr_rdata, 32'h888);
    idle(); step(); step();
    check("pend_masked", {31'b0, irq_take}, 32'h0);
    mret = 1;
    step(); mret = 0; #1;
    check("mret_take", {31'b0, irq_take}, 32'h1);
    check("mret_cause", irq_cause, 32'h8000000B);
    check("mret_mepc", mepc_o, 32'h1234);
    rd(12'h300); check("mret_mstatus", csr_rdata, 32'h1888);
    idle(); irq_ext = 0;
    step(); step();
    check("cause_sw", irq_cause, 32'h80000003);

    // same-cycle trap + mret + write: only trap visible
    trap_valid = 1; trap_pc = 32'h2000; trap_cause = 32'h5; trap_tval = 32'hABC; mret = 1;
    set_req(1, 0, CSR_MODE_RW, 12'h300, 32'h0, 0, 1);
    step(); trap_valid = 0; mret = 0;
    rd(12'h300); check("prio_mstatus", csr_rdata, 32'h1880);
    check("prio_mepc", mepc_o, 32'h2000);
    rd(12'h342); check("prio_mcause", csr_rdata, 32'h5);
    rd(12'h343); check("prio_mtval", csr_rdata, 32'hABC);
    // mret beats a CSR write
    mret = 1;
    set_req(1, 0, CSR_MODE_RW, 12'h300, 32'h0, 0, 1);
    step(); mret = 0;
    rd(12'h300); check("mret_over_wr", csr_rdata, 32'h1888);

    // read-only and masked registers
    set_req(1, 0, CSR_MODE_RW, 12'hF14, 32'h0, 0, 1);
    step(); rd(12'hF14); check("hartid_ro", csr_rdata, 32'd5);
    set_req(1, 0, CSR_MODE_RW, 12'h344, 32'hFFFFFFFF, 0, 1);
    step(); rd(12'h344); check("mip_ro", csr_rdata, 32'h8);
    set_req(1, 0, CSR_MODE_RW, 12'h341, 32'h12345677, 0, 1);
    step(); idle(); #1; check("mepc_align", mepc_o, 32'h12345674);

    // asynchronous reset with a pending write
    set_req(1, 0, CSR_MODE_RW, 12'h340, 32'h55, 0, 1);
    trap_cause = 32'h8000000B;
    #2 rst_n = 1'b0;
    idle(); #1;
    check("rst_rdata", csr_rdata, 32'h0);
    check("rst_vector", trap_vector, 32'h0);
    check("rst_mepc", mepc_o, 32'h0);
    check("rst_take", {31'b0, irq_take}, 32'h0);
    check("rst_cause", irq_cause, 32'h0);
    step();
    #2 rst_n = 1'b1;
    step(); rd(12'h340);
    check("rst_mscratch", csr_rdata, 32'h0);
    idle();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
